// File: rtl/control_fsm.sv
// Multi-cycle control unit: accepts one opcode per FETCH visit and sequences the
// datapath through DECODE, EXECUTE, MEM and WRITEBACK, with a sticky trap for
// illegal opcodes and data-memory timeouts.
module control_fsm #(
  parameter int unsigned OPCODE_W    = 5,
  parameter int unsigned JUMP_OP     = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                instr_ready,
  input  logic                cond_true,
  input  logic                mem_ack,
  input  logic                trap_clear,
  output logic                branch_en,
  output logic                jump_en,
  output logic                immediate_en,
  output logic                write_en,
  output logic                alu_en,
  output logic                mem_req,
  output logic                reg_write,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                illegal,
  output logic [2:0]          state
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExecute = 3'd2,
    StMem     = 3'd3,
    StWb      = 3'd4,
    StTrap    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsNop, ClsR, ClsI, ClsBranch, ClsJump, ClsIllegal
  } cls_e;

  state_e                state_q, state_d;
  logic [OPCODE_W-1:0]   op_q, op_d;
  logic [3:0]            en_q, en_d;   // {branch, jump, immediate, write}
  logic                  ill_q, ill_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [31:0]           op_u;
  cls_e                  cls;
  logic [3:0]            cls_en;
  logic                  mem_last;

  assign op_u     = 32'(op_q);
  // Final allowed MEM cycle: the counter holds the number of MEM cycles already spent.
  assign mem_last = (cnt_q == CntW'(MEM_TIMEOUT - 1));

  // Classify the latched opcode and derive its class enables.
  always_comb begin
    cls    = ClsIllegal;
    cls_en = 4'b0000;
    if (op_u == 32'd0) begin
      cls = ClsNop;
    end else if (op_u <= 32'd8) begin
      cls = ClsR;
    end else if (op_u <= 32'd11) begin
      cls    = ClsI;
      cls_en = 4'b0011;
    end else if (op_u <= 32'd15) begin
      cls    = ClsBranch;
      cls_en = 4'b1001;
    end else if (op_u == JUMP_OP) begin
      cls    = ClsJump;
      cls_en = 4'b0100;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    en_d        = en_q;
    ill_d       = ill_q;
    cnt_d       = cnt_q;
    instr_ready = 1'b0;
    alu_en      = 1'b0;
    mem_req     = 1'b0;
    reg_write   = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    case (state_q)
      StFetch: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          op_d    = opcode;
          state_d = StDecode;
        end
      end
      StDecode: begin
        en_d = cls_en;
        if (cls == ClsNop) begin
          pc_inc  = 1'b1;
          state_d = StFetch;
        end else if (cls == ClsIllegal) begin
          ill_d   = 1'b1;
          state_d = StTrap;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        alu_en = 1'b1;
        case (cls)
          ClsR: state_d = StWb;
          ClsI: begin
            cnt_d   = '0;
            state_d = StMem;
          end
          ClsBranch: begin
            pc_load = cond_true;
            pc_inc  = ~cond_true;
            state_d = StFetch;
          end
          ClsJump: begin
            pc_load = 1'b1;
            state_d = StFetch;
          end
          default: state_d = StFetch;
        endcase
      end
      StMem: begin
        mem_req = 1'b1;
        // Ack in the final allowed cycle wins over the timeout.
        if (mem_ack) begin
          state_d = StWb;
        end else if (mem_last) begin
          ill_d   = 1'b1;
          state_d = StTrap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWb: begin
        reg_write = 1'b1;
        pc_inc    = 1'b1;
        state_d   = StFetch;
      end
      StTrap: begin
        if (trap_clear) begin
          ill_d   = 1'b0;
          en_d    = 4'b0000;
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // State and datapath-control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      op_q    <= '0;
      en_q    <= 4'b0000;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      en_q    <= en_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign branch_en    = en_q[3];
  assign jump_en      = en_q[2];
  assign immediate_en = en_q[1];
  assign write_en     = en_q[0];
  assign illegal      = ill_q;
  assign state        = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed scenarios plus random traffic, every cycle
// compared against a schedule-based model of the instruction lifecycle.
module tb_control_fsm;
  localparam int OW  = 5;
  localparam int JOP = 16;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid, cond_true, mem_ack, trap_clear;
  logic [OW-1:0] opcode;
  logic          instr_ready, branch_en, jump_en, immediate_en, write_en;
  logic          alu_en, mem_req, reg_write, pc_inc, pc_load, illegal;
  logic [2:0]    state;

  control_fsm #(.OPCODE_W(OW), .JUMP_OP(JOP), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(instr_ready), .cond_true(cond_true), .mem_ack(mem_ack),
    .trap_clear(trap_clear), .branch_en(branch_en), .jump_en(jump_en),
    .immediate_en(immediate_en), .write_en(write_en), .alu_en(alu_en),
    .mem_req(mem_req), .reg_write(reg_write), .pc_inc(pc_inc), .pc_load(pc_load),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 = waiting for an instruction, 1 = instruction in flight, 2 = trapped.
  // cls: 0 NOP, 1 R, 2 I, 3 branch, 4 jump, 5 illegal. step = cycles since handshake.
  int         mode, cls, step, memn;
  bit         wbph;
  logic [3:0] m_en;
  bit         m_ill;

  // Per-scenario observations of the DUT (cycle 0 = handshake cycle).
  int         sc_cyc, f_alu, f_inc, f_load, f_rw, f_rdy, n_memreq, n_pulse;
  logic [2:0] last_st;
  logic       last_ill;
  logic [3:0] last_en;

  function automatic int classify(int op);
    if (op == 0) return 0;
    if (op <= 8) return 1;
    if (op <= 11) return 2;
    if (op <= 15) return 3;
    if (op == JOP) return 4;
    return 5;
  endfunction

  function automatic logic [3:0] class_en(int c);
    case (c)
      2: return 4'b0011;
      3: return 4'b1001;
      4: return 4'b0100;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [13:0] model_out(bit cond);
    logic rdy = 0, alu = 0, mr = 0, rw = 0, inc = 0, ld = 0;
    logic [2:0] st = 3'd0;
    if (mode == 0) begin
      rdy = 1;
    end else if (mode == 2) begin
      st = 3'd5;
    end else if (step == 1) begin
      st = 3'd1;
      inc = (cls == 0);
    end else if (step == 2) begin
      st = 3'd2;
      alu = 1;
      if (cls == 3) begin
        ld = cond;
        inc = !cond;
      end
      if (cls == 4) ld = 1;
    end else if (cls == 2 && !wbph) begin
      st = 3'd3;
      mr = 1;
    end else begin
      st = 3'd4;
      rw = 1;
      inc = 1;
    end
    return {rdy, m_en, alu, mr, rw, inc, ld, m_ill, st};
  endfunction

  task automatic model_step(bit v, int op, bit ack, bit clr);
    case (mode)
      0: if (v) begin
        mode = 1; step = 1; cls = classify(op); wbph = 0; memn = 0;
      end
      1: begin
        if (step == 1) begin
          m_en = class_en(cls);
          if (cls == 0) mode = 0;
          else if (cls == 5) begin m_ill = 1; mode = 2; end
          else step = 2;
        end else if (step == 2) begin
          if (cls == 1 || cls == 2) step = 3;
          else mode = 0;
        end else if (cls == 1 || wbph) begin
          mode = 0;
        end else begin
          memn++;
          if (ack) wbph = 1;
          else if (memn == TMO) begin m_ill = 1; mode = 2; end
        end
      end
      default: if (clr) begin m_ill = 0; m_en = 4'b0000; mode = 0; end
    endcase
  endtask

  function automatic logic [13:0] dut_vec();
    return {instr_ready, branch_en, jump_en, immediate_en, write_en, alu_en, mem_req,
            reg_write, pc_inc, pc_load, illegal, state};
  endfunction

  task automatic check_vec(string name, logic [13:0] got, logic [13:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic scen_reset();
    sc_cyc = 0; f_alu = -1; f_inc = -1; f_load = -1; f_rw = -1; f_rdy = -1;
    n_memreq = 0; n_pulse = 0;
  endtask

  // One clock: drive inputs at the falling edge, compare, then advance the model.
  task automatic step_cycle(bit v, int op, bit cond, bit ack, bit clr);
    @(negedge clk);
    instr_valid = v; opcode = op[OW-1:0]; cond_true = cond; mem_ack = ack; trap_clear = clr;
    #1;
    check_vec("cycle", dut_vec(), model_out(cond));
    if (alu_en && f_alu < 0) f_alu = sc_cyc;
    if (pc_inc && f_inc < 0) f_inc = sc_cyc;
    if (pc_load && f_load < 0) f_load = sc_cyc;
    if (reg_write && f_rw < 0) f_rw = sc_cyc;
    if (instr_ready && sc_cyc > 0 && f_rdy < 0) f_rdy = sc_cyc;
    if (mem_req) n_memreq++;
    if (pc_inc || pc_load) n_pulse++;
    last_st = state; last_ill = illegal;
    last_en = {branch_en, jump_en, immediate_en, write_en};
    sc_cyc++;
    model_step(v, op, ack, clr);
  endtask

  task automatic do_reset(int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      rst_n = 0; instr_valid = 0; opcode = '0; cond_true = 0; mem_ack = 0; trap_clear = 0;
      #1;
      mode = 0; m_en = 4'b0000; m_ill = 0;
      check_vec("reset", dut_vec(), 14'b1_0000_000000_000);
    end
    rst_n = 1;
    model_step(0, 0, 0, 0);
  endtask

  // Issue one opcode and run it until it retires or traps; ack on MEM cycle ack_at.
  task automatic run_instr(int op, bit cond, int ack_at);
    bit ack;
    scen_reset();
    step_cycle(1, op, cond, 0, 0);
    for (int k = 0; k < 40 && mode == 1; k++) begin
      ack = (ack_at != 0 && cls == 2 && step >= 3 && !wbph && memn + 1 == ack_at);
      step_cycle(0, op, cond, ack, 0);
    end
    check_int("instr_bound", int'(mode == 1), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mode = 0; cls = 0; step = 0; memn = 0; wbph = 0; m_en = 4'b0000; m_ill = 0;
    rst_n = 1; instr_valid = 0; opcode = '0; cond_true = 0; mem_ack = 0; trap_clear = 0;
    #2;
    do_reset(2);

    // R-type
    run_instr(3, 0, 0);
    check_int("r_alu", f_alu, 2);
    check_int("r_inc", f_inc, 3);
    check_int("r_rw", f_rw, 3);
    step_cycle(0, 0, 0, 0, 0);
    check_int("r_ready", f_rdy, 4);
    check_int("r_en", int'(last_en), 0);

    // I-type, ack on 4th MEM cycle
    run_instr(10, 0, 4);
    check_int("i_memreq", n_memreq, 4);
    check_int("i_rw", f_rw, 7);
    check_int("i_en", int'(last_en), 3);

    // Branch taken / not taken, jump
    run_instr(12, 1, 0);
    check_int("br_t_load", f_load, 2);
    check_int("br_t_pulses", n_pulse, 1);
    run_instr(12, 0, 0);
    check_int("br_n_inc", f_inc, 2);
    check_int("br_n_load", f_load, -1);
    run_instr(16, 0, 0);
    check_int("jmp_load", f_load, 2);
    check_int("jmp_en", int'(last_en), 4);

    // Illegal opcode and trap clear
    run_instr(20, 0, 0);
    step_cycle(0, 0, 0, 0, 0);
    check_int("ill_state", int'(last_st), 5);
    check_int("ill_flag", int'(last_ill), 1);
    check_int("ill_pulses", n_pulse, 0);
    step_cycle(0, 0, 0, 0, 1);
    step_cycle(0, 0, 0, 0, 0);
    check_int("clr_state", int'(last_st), 0);
    check_int("clr_flag", int'(last_ill), 0);

    // MEM timeout boundary
    run_instr(11, 0, 0);
    check_int("tmo_memreq", n_memreq, 15);
    step_cycle(0, 0, 0, 0, 0);
    check_int("tmo_state", int'(last_st), 5);
    check_int("tmo_pulses", n_pulse, 0);
    step_cycle(0, 0, 0, 0, 1);
    run_instr(11, 0, 15);
    check_int("ack15_memreq", n_memreq, 15);
    check_int("ack15_rw", f_rw, 18);
    check_int("ack15_ill", int'(last_ill), 0);

    // Reset mid-MEM
    scen_reset();
    step_cycle(1, 9, 0, 0, 0);
    for (int k = 0; k < 4; k++) step_cycle(0, 9, 0, 0, 0);
    check_int("rst_in_mem", int'(last_st), 3);
    do_reset(2);
    step_cycle(0, 0, 0, 0, 0);
    check_int("rst_pulses", n_pulse, 0);

    // Random traffic, with held instr_valid and occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(1);
      end else begin
        step_cycle($urandom_range(0, 9) < 7, int'($urandom_range(0, 20)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                   $urandom_range(0, 3) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control unit for the 60-bit processor, replacing the single-cycle opcode decoder. It accepts one instruction at a time from the fetch stage over a valid/ready handshake and decodes the opcode class (R, I, branch, jump, NOP, illegal). It then sequences the datapath through DECODE, EXECUTE, MEM and WRITEBACK states, driving per-instruction enables and PC-update pulses. It adds real jump support, a data-memory request/acknowledge handshake with timeout, and a sticky trap for illegal opcodes and memory timeouts.

## Interface
- OPCODE_W, 5, opcode width; must be ≥5.
- JUMP_OP, 16, opcode value decoded as jump.
- MEM_TIMEOUT, 15, maximum MEM cycles without `mem_ack` before trapping; must be ≥1.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- instr_valid  in  1  fetch stage presents an opcode.
- opcode  in  OPCODE_W  instruction opcode; sampled only on the handshake.
- instr_ready  out  1  control unit accepts an opcode; high only in FETCH.
- cond_true  in  1  ALU branch condition; sampled only in EXECUTE for branches.
- mem_ack  in  1  data memory done; used only in MEM.
- trap_clear  in  1  leaves TRAP; used only in TRAP.
- branch_en, jump_en, immediate_en, write_en  out  1 each  decoded class levels; registered in DECODE and held until the next handshake.
- alu_en  out  1  high for the EXECUTE cycle.
- mem_req  out  1  high throughout MEM.
- reg_write  out  1  high for the WRITEBACK cycle.
- pc_inc  out  1  one-cycle pulse: PC += 1.
- pc_load  out  1  one-cycle pulse: PC ← target.
- illegal  out  1  sticky trap flag.
- state  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5.

## Operation
- **Decode classes** (opcode as unsigned):
  - 0: NOP.
  - 1–8: R-type; all four enables = 0.
  - 9–11: I-type; `immediate_en` = 1, `write_en` = 1.
  - 12–15: branch; `branch_en` = 1, `write_en` = 1.
  - JUMP_OP: `jump_en` = 1.
  - Any other value: illegal.
- **FETCH:** `instr_ready` = 1. On `instr_valid` & `instr_ready`, latch the opcode and go to DECODE.
- **DECODE:** register the class enables.
  - NOP: pulse `pc_inc`, go to FETCH.
  - Illegal: set `illegal`, go to TRAP.
  - Otherwise: go to EXECUTE.
- **EXECUTE:** `alu_en` = 1.
  - R-type: go to WB.
  - I-type: go to MEM.
  - Branch: pulse `pc_load` if `cond_true`, else pulse `pc_inc`; go to FETCH.
  - Jump: pulse `pc_load`; go to FETCH.
- **MEM:** `mem_req` = 1; the timeout counter counts the cycles spent in MEM.
  - `mem_ack`: go to WB.
  - Counter reaches MEM_TIMEOUT cycles without ack: set `illegal`, go to TRAP.
  - Ack in the final allowed cycle wins over the timeout.
- **WB:** `reg_write` = 1, pulse `pc_inc`, go to FETCH.
- **TRAP:** all pulses and requests low; enables hold. `trap_clear` clears `illegal`, zeroes the enables and goes to FETCH.
- `instr_valid` outside FETCH, `mem_ack` outside MEM, `cond_true` outside a branch EXECUTE, and `trap_clear` outside TRAP are all ignored.
- Counter width is $clog2(MEM_TIMEOUT+1); the counter resets on entry to MEM.

## Timing
- **Reset:** asynchronous, any state. `state` = FETCH; every output 0 except `instr_ready` = 1. An in-flight instruction is abandoned with no PC pulse.
- **Latency after handshake edge** (cycle 1 = DECODE):
  - NOP: 1 cycle.
  - Branch / jump: 2 cycles.
  - R-type: 3 cycles.
  - I-type: 3 + N cycles, where N ≥ 1 is the number of MEM cycles up to and including the ack.
- Next `instr_ready` is asserted in the cycle after the final pulse.
- Exactly one of `pc_inc` / `pc_load` pulses per non-trapping instruction; none for trapping ones.
- Back-to-back: holding `instr_valid` high gives one handshake per FETCH visit, never two in a row.

## Test plan
- **Reset mid-MEM:** opcode 9, `mem_ack` withheld, `rst_n` low for 2 cycles → `state` = 0, `mem_req` = 0, `instr_ready` = 1, no `pc_inc`.
- **R-type:** opcode 3 → `alu_en` at cycle 2; `reg_write` and `pc_inc` at cycle 3; `instr_ready` at cycle 4; enables all 0.
- **I-type, delayed ack:** opcode 10, `mem_ack` on the 4th MEM cycle → `immediate_en` = `write_en` = 1, `mem_req` high for 4 cycles, `reg_write` the cycle after.
- **Branch and jump:** opcode 12 with `cond_true` = 1 → `pc_load` at cycle 2. Repeat with `cond_true` = 0 → `pc_inc` at cycle 2. Opcode 16 → `jump_en` = 1, `pc_load` at cycle 2.
- **Illegal opcode:** opcode 20 → `illegal` = 1, `state` = 5, no PC pulse. `trap_clear` → `illegal` = 0, `state` = 0.
- **MEM timeout boundary:** opcode 11 with no ack → TRAP after exactly 15 MEM cycles. Ack on cycle 15 → WB with no trap.
